// File: rtl/eth_bringup_seq.sv
// Reset/bring-up sequencer for the 1G SFP path: staged PHY, SoC and MAC resets gated on link stability.
// Optional run-time link-loss recovery is enabled by defining BRINGUP_RELINK_EN.
module eth_bringup_seq #(
  parameter int PHY_RST_CYCLES      = 2500000,
  parameter int LINK_TIMEOUT_CYCLES = 50000000,
  parameter int SETTLE_CYCLES       = 500000,
  parameter int LOSS_CYCLES         = 50000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       c10_clk50m,
  input  logic       clean_rst_long_n,
  input  logic [1:0] link_up_i,
  input  logic [1:0] port_en_i,
  output logic       phy_rst_n_o,
  output logic       soc_rst_n_o,
  output logic       mac_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int MAX_PT  = (PHY_RST_CYCLES > LINK_TIMEOUT_CYCLES) ? PHY_RST_CYCLES : LINK_TIMEOUT_CYCLES;
  localparam int MAX_SL  = (SETTLE_CYCLES > LOSS_CYCLES) ? SETTLE_CYCLES : LOSS_CYCLES;
  localparam int MAX_CYC = (MAX_PT > MAX_SL) ? MAX_PT : MAX_SL;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // PHY_RST is held one cycle longer than its count; the other states run exactly their count
  localparam cnt_t       LD_PHY    = cnt_t'(PHY_RST_CYCLES);
  localparam cnt_t       LD_LINK   = cnt_t'(LINK_TIMEOUT_CYCLES - 1);
  localparam cnt_t       LD_SETTLE = cnt_t'(SETTLE_CYCLES - 1);
  localparam cnt_t       LD_LOSS   = cnt_t'(LOSS_CYCLES - 1);
  localparam logic [1:0] MAX_R     = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PHY_RST   = 3'd0,
    LINK_WAIT = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] retry_q, retry_d;
  logic [1:0] sync1, lnk_s;
  logic       all_up;

  assign all_up = &(lnk_s | ~port_en_i);

`ifdef BRINGUP_RELINK_EN
  logic any_down;
  assign any_down = |(~lnk_s & port_en_i);
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - cnt_t'(1);
    case (state_q)
      PHY_RST: begin
        if (cnt_q == '0) begin
          state_d = LINK_WAIT;
          cnt_d   = LD_LINK;
        end
      end
      LINK_WAIT: begin
        // link-up takes priority over a coincident timeout
        if (all_up) begin
          state_d = SETTLE;
          cnt_d   = LD_SETTLE;
        end else if (cnt_q == '0) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 2'd1;
            state_d = PHY_RST;
            cnt_d   = LD_PHY;
          end else begin
            state_d = FAIL;
          end
        end
      end
      SETTLE: begin
        if (!all_up) begin
          state_d = LINK_WAIT;
          cnt_d   = LD_LINK;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          retry_d = '0;
          cnt_d   = LD_LOSS;
        end
      end
      RUN: begin
`ifdef BRINGUP_RELINK_EN
        if (!any_down) begin
          cnt_d = LD_LOSS;
        end else if (cnt_q == '0) begin
          state_d = LINK_WAIT;
          cnt_d   = LD_LINK;
        end
`else
        cnt_d = LD_LOSS;
`endif
      end
      FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = PHY_RST;
        cnt_d   = LD_PHY;
      end
    endcase
  end

  // outputs are registered from the next state so they line up with state_o
  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      state_q     <= PHY_RST;
      cnt_q       <= LD_PHY;
      retry_q     <= '0;
      sync1       <= '0;
      lnk_s       <= '0;
      phy_rst_n_o <= 1'b0;
      soc_rst_n_o <= 1'b0;
      mac_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1       <= link_up_i;
      lnk_s       <= sync1;
      phy_rst_n_o <= (state_d != PHY_RST);
      soc_rst_n_o <= soc_rst_n_o | (state_d != PHY_RST);
      mac_rst_n_o <= (state_d == RUN);
      ready_o     <= (state_d == RUN);
      fail_o      <= (state_d == FAIL);
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_eth_bringup_seq.sv
// Scoreboard bench for eth_bringup_seq with shortened timing parameters.
// Link-loss expectations follow whether BRINGUP_RELINK_EN is defined for the build.
module tb_eth_bringup_seq;

  localparam int P = 10;
  localparam int T = 40;
  localparam int S = 8;
  localparam int L = 5;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] link_up = 2'b00;
  logic [1:0] port_en = 2'b00;
  logic       phy, soc, mac, ready, fail;
  logic [1:0] retry;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];

  always #10 clk = ~clk;

  eth_bringup_seq #(
    .PHY_RST_CYCLES(P),
    .LINK_TIMEOUT_CYCLES(T),
    .SETTLE_CYCLES(S),
    .LOSS_CYCLES(L),
    .MAX_RETRIES(R)
  ) dut (
    .c10_clk50m(clk),
    .clean_rst_long_n(rst_n),
    .link_up_i(link_up),
    .port_en_i(port_en),
    .phy_rst_n_o(phy),
    .soc_rst_n_o(soc),
    .mac_rst_n_o(mac),
    .ready_o(ready),
    .fail_o(fail),
    .retry_cnt_o(retry),
    .state_o(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [1:0] en, input logic [1:0] lk);
    rst_n = 1'b0;
    port_en = en;
    link_up = lk;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  function automatic int outvec();
    return int'({phy, soc, mac, ready, fail, retry, state});
  endfunction

  task automatic test_reset();
    int e;
    rst_n = 1'b0;
    port_en = 2'b01;
    #3;
    exp_q.push_back(0);
    e = exp_q.pop_front();
    checks++;
    if (outvec() !== e) begin errors++; $display("FAIL reset_outputs: got %0h expected %0h", outvec(), e); end
    do_reset(2'b01, 2'b00);
    repeat (P) step();
    exp_q.push_back(0);
    e = exp_q.pop_front();
    checks++;
    if (int'(phy) !== e) begin errors++; $display("FAIL phy_still_low_at_P: got %0d expected %0d", phy, e); end
  endtask

  task automatic test_nominal();
    int e, e2, rise_phy, rise_mac, st;
    do_reset(2'b01, 2'b00);
    exp_q.push_back(P + 1);
    exp_q.push_back(1);
    exp_q.push_back(20 + S + 3);
    exp_q.push_back(20 + S + 4);
    exp_q.push_back(int'({1'b1, 1'b1, 2'b00, 3'd3}));
    rise_phy = -1; rise_mac = -1; st = -1;
    for (int i = 0; i < 80 && rise_mac < 0; i++) begin
      step();
      if (cyc == 20) link_up = 2'b01;
      if (phy && rise_phy < 0) begin rise_phy = cyc; st = int'(state); end
      if (mac && rise_mac < 0) rise_mac = cyc;
    end
    e = exp_q.pop_front(); checks++;
    if (rise_phy !== e) begin errors++; $display("FAIL nominal_phy_rise: got %0d expected %0d", rise_phy, e); end
    e = exp_q.pop_front(); checks++;
    if (st !== e) begin errors++; $display("FAIL nominal_state_link_wait: got %0d expected %0d", st, e); end
    e = exp_q.pop_front(); e2 = exp_q.pop_front(); checks++;
    if (rise_mac < e || rise_mac > e2) begin errors++; $display("FAIL nominal_mac_rise: got %0d expected %0d..%0d", rise_mac, e, e2); end
    e = exp_q.pop_front(); checks++;
    if (int'({ready, soc, retry, state}) !== e) begin
      errors++; $display("FAIL nominal_run_status: got %0h expected %0h", {ready, soc, retry, state}, e);
    end
  endtask

  task automatic test_timeout();
    int e, pulses, maxr, fail_cyc, soc_viol;
    logic prev_phy;
    do_reset(2'b11, 2'b00);
    exp_q.push_back(3);
    exp_q.push_back(R);
    exp_q.push_back(3 * (P + 1) + 3 * T);
    exp_q.push_back(0);
    exp_q.push_back(int'({1'b1, 1'b0, 1'b1, 3'd4}));
    pulses = 1; maxr = 0; fail_cyc = -1; soc_viol = 0; prev_phy = 1'b0;
    for (int i = 0; i < 400 && fail_cyc < 0; i++) begin
      step();
      if (prev_phy && !phy) pulses++;
      if (cyc > P + 1 && !soc) soc_viol++;
      prev_phy = phy;
      if (int'(retry) > maxr) maxr = int'(retry);
      if (fail) fail_cyc = cyc;
    end
    link_up = 2'b11;
    repeat (60) step();
    e = exp_q.pop_front(); checks++;
    if (pulses !== e) begin errors++; $display("FAIL timeout_phy_pulses: got %0d expected %0d", pulses, e); end
    e = exp_q.pop_front(); checks++;
    if (maxr !== e) begin errors++; $display("FAIL timeout_max_retry: got %0d expected %0d", maxr, e); end
    e = exp_q.pop_front(); checks++;
    if (fail_cyc !== e) begin errors++; $display("FAIL timeout_fail_cycle: got %0d expected %0d", fail_cyc, e); end
    e = exp_q.pop_front(); checks++;
    if (soc_viol !== e) begin errors++; $display("FAIL timeout_soc_sticky: got %0d expected %0d", soc_viol, e); end
    e = exp_q.pop_front(); checks++;
    if (int'({phy, mac, fail, state}) !== e) begin
      errors++; $display("FAIL fail_terminal: got %0h expected %0h", {phy, mac, fail, state}, e);
    end
  endtask

  task automatic test_settle_abort();
    int e, e2, returns, rise_mac;
    logic [2:0] prev_state;
    do_reset(2'b01, 2'b00);
    exp_q.push_back(1);
    exp_q.push_back(25 + S + 3);
    exp_q.push_back(25 + S + 4);
    returns = 0; rise_mac = -1; prev_state = 3'd0;
    for (int i = 0; i < 100 && rise_mac < 0; i++) begin
      step();
      if (cyc == 20) link_up = 2'b01;
      if (cyc == 24) link_up = 2'b00;
      if (cyc == 25) link_up = 2'b01;
      if (prev_state == 3'd2 && state == 3'd1) returns++;
      prev_state = state;
      if (mac && rise_mac < 0) rise_mac = cyc;
    end
    e = exp_q.pop_front(); checks++;
    if (returns !== e) begin errors++; $display("FAIL settle_abort_return: got %0d expected %0d", returns, e); end
    e = exp_q.pop_front(); e2 = exp_q.pop_front(); checks++;
    if (rise_mac < e || rise_mac > e2) begin errors++; $display("FAIL settle_abort_mac_rise: got %0d expected %0d..%0d", rise_mac, e, e2); end
  endtask

  task automatic test_link_loss();
    int e, reached, short_drops, dropped, st_at, phy_at;
    do_reset(2'b01, 2'b01);
    exp_q.push_back(1);
    reached = 0;
    for (int i = 0; i < 60 && reached == 0; i++) begin
      step();
      if (ready) reached = 1;
    end
    e = exp_q.pop_front(); checks++;
    if (reached !== e) begin errors++; $display("FAIL loss_reach_run: got %0d expected %0d", reached, e); end

    exp_q.push_back(0);
    short_drops = 0;
    link_up = 2'b00;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 3) link_up = 2'b01;
      if (!mac || state != 3'd3) short_drops++;
    end
    e = exp_q.pop_front(); checks++;
    if (short_drops !== e) begin errors++; $display("FAIL loss_short_drop: got %0d expected %0d", short_drops, e); end

`ifdef BRINGUP_RELINK_EN
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(1);
`else
    exp_q.push_back(0);
    exp_q.push_back(3);
    exp_q.push_back(1);
`endif
    dropped = 0; st_at = -1; phy_at = -1;
    link_up = 2'b00;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 5) link_up = 2'b01;
      if (!mac && dropped == 0) begin dropped = 1; st_at = int'(state); phy_at = int'(phy); end
    end
`ifndef BRINGUP_RELINK_EN
    st_at = int'(state);
    phy_at = int'(ready);
`endif
    e = exp_q.pop_front(); checks++;
    if (dropped !== e) begin errors++; $display("FAIL loss_long_drop: got %0d expected %0d", dropped, e); end
    e = exp_q.pop_front(); checks++;
    if (st_at !== e) begin errors++; $display("FAIL loss_state: got %0d expected %0d", st_at, e); end
    e = exp_q.pop_front(); checks++;
    if (phy_at !== e) begin errors++; $display("FAIL loss_phy_or_ready: got %0d expected %0d", phy_at, e); end
  endtask

  task automatic test_async_reset();
    int e, e2, found, retry_viol, rise_phy, rise_mac;
    do_reset(2'b01, 2'b00);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (retry == 2'd1 && state == 3'd1) found = 1;
    end
    link_up = 2'b01;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (state == 3'd2) found = 1;
    end
    step();
    exp_q.push_back(int'({1'b1, 1'b1, 2'd1, 3'd2}));
    e = exp_q.pop_front(); checks++;
    if (int'({phy, soc, retry, state}) !== e) begin
      errors++; $display("FAIL arst_precondition: got %0h expected %0h", {phy, soc, retry, state}, e);
    end
    #5;
    rst_n = 1'b0;
    exp_q.push_back(0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (outvec() !== e) begin errors++; $display("FAIL arst_outputs: got %0h expected %0h", outvec(), e); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    exp_q.push_back(P + 1);
    exp_q.push_back(0);
    exp_q.push_back(P + S + 1);
    exp_q.push_back(P + S + 4);
    retry_viol = 0; rise_phy = -1; rise_mac = -1;
    for (int i = 0; i < 60 && rise_mac < 0; i++) begin
      step();
      if (retry != 2'd0) retry_viol++;
      if (phy && rise_phy < 0) rise_phy = cyc;
      if (mac && rise_mac < 0) rise_mac = cyc;
    end
    e = exp_q.pop_front(); checks++;
    if (rise_phy !== e) begin errors++; $display("FAIL arst_phy_rise: got %0d expected %0d", rise_phy, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_viol !== e) begin errors++; $display("FAIL arst_retry_zero: got %0d expected %0d", retry_viol, e); end
    e = exp_q.pop_front(); e2 = exp_q.pop_front(); checks++;
    if (rise_mac < e || rise_mac > e2) begin errors++; $display("FAIL arst_mac_rise: got %0d expected %0d..%0d", rise_mac, e, e2); end
  endtask

  task automatic test_no_ports();
    int e, e2, rise_mac;
    do_reset(2'b00, 2'b00);
    exp_q.push_back(P + S + 1);
    exp_q.push_back(P + S + 4);
    exp_q.push_back(int'({1'b1, 1'b0, 2'd0, 3'd3}));
    rise_mac = -1;
    for (int i = 0; i < 60 && rise_mac < 0; i++) begin
      step();
      if (mac && rise_mac < 0) rise_mac = cyc;
    end
    e = exp_q.pop_front(); e2 = exp_q.pop_front(); checks++;
    if (rise_mac < e || rise_mac > e2) begin errors++; $display("FAIL noports_mac_rise: got %0d expected %0d..%0d", rise_mac, e, e2); end
    e = exp_q.pop_front(); checks++;
    if (int'({ready, fail, retry, state}) !== e) begin
      errors++; $display("FAIL noports_status: got %0h expected %0h", {ready, fail, retry, state}, e);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_settle_abort();
    test_link_loss();
    test_async_reset();
    test_no_ports();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
